data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the pipeline's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then commits the write or performs the read against an internal word array, and returns one response per request over a second valid/ready handshake. It replaces the zero-latency data memory so the core and its stall logic can be exercised against realistic, multi-cycle memory.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of two and at least 4.
- WAIT_STATES, 2: extra cycles between accept and response; range 0–15.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (low = in reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i covers bits [8i+7:8i]; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_error  out  1  request was misaligned or out of range.
- busy  out  1  high in WAIT or RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch write, addr, wdata and be.
  - Go to WAIT if WAIT_STATES>0, else go directly to RESP.
- WAIT:
  - A 4-bit counter loads WAIT_STATES-1 on accept and decrements each cycle.
  - At count 0, go to RESP.
- Access happens on the transition edge into RESP:
  - Stores write only the enabled bytes.
  - Loads capture the full word into rsp_rdata.
- Error check is evaluated on the latched request:
  - Misaligned: addr[1:0]!=0.
  - Out of range: addr >= DEPTH_WORDS*4.
  - On error: no write, rsp_rdata=0, rsp_error=1.
- Word index is addr[log2(DEPTH_WORDS)+1:2].
- RESP:
  - rsp_valid=1, and rsp_rdata/rsp_error are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - req_ready stays low, so the next request cannot be accepted in the same cycle (no back-to-back overlap).
- A store with req_be=0 is legal: no bytes change, and the response is sent normally.
- Request inputs are don't-care outside the accept cycle. The latched copy is the only one used.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, counter=0.
- Memory contents are not cleared by reset.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the accept edge.
  - WAIT_STATES=0: rsp_valid is high the cycle after accept.
  - WAIT_STATES=2: three cycles after accept.
- Minimum request spacing is WAIT_STATES+2 cycles, reached when rsp_ready is held high.
- Response back-pressure: if rsp_ready=0, the FSM stays in RESP indefinitely with outputs frozen. A store already committed is never re-applied.
- Reset asserted mid-transaction:
  - The FSM goes to IDLE immediately and the transaction is dropped with no response.
  - If reset asserts before the commit edge, the store does not happen.
  - If reset asserts after the commit edge, the store persists.
- Reads after writes to the same word observe the new data. The array has no read-modify-write hazard because only one transaction is ever in flight.

## Structure
- Package data_mem_resp_pkg holds:
  - The state enum (IDLE, WAIT, RESP).
  - The byte-enable width constant (4).
  - A helper function for the error check, taking addr and DEPTH_WORDS.
- Sub-module mem_word_array holds:
  - DEPTH_WORDS×32 storage, with per-byte write enables and a synchronous write.
  - A registered read port.
  - No reset on the storage.
- The top level contains the FSM, the wait counter, the request latch and the response registers.

## Test plan
- Reset and idle:
  - Hold reset low, then release it.
  - Required: req_ready=1, rsp_valid=0, busy=0.
  - Required: no response appears without a request.
- Store then load, WAIT_STATES=2:
  - Store 0xDEADBEEF to 0x10 with be=4'hF.
  - Required: rsp_valid rises exactly 3 cycles after accept, with rsp_error=0 and rsp_rdata=0.
  - Load 0x10. Required: rsp_rdata=0xDEADBEEF.
- Partial store:
  - Start from word 0x10 = 0xDEADBEEF, then store 0x00001234 with be=4'b0011.
  - Load 0x10. Required: 0xDEAD1234.
- Errors:
  - Load 0x13. Required: rsp_error=1, rsp_rdata=0.
  - Store to DEPTH_WORDS*4 (0x400). Required: rsp_error=1.
  - Load word 0. Required: its contents are unchanged.
- Back-pressure:
  - Hold rsp_ready=0 for 10 cycles during a load.
  - Required: rsp_valid and rsp_rdata stay stable and req_ready=0.
  - Raise rsp_ready. Required: IDLE follows on the next cycle.
- Reset during WAIT:
  - Accept a store to 0x20, then assert reset one cycle later.
  - Required: no response is sent, and a later load of 0x20 returns its prior value.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding and the request error check.
package data_mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int BE_W = 4;

  function automatic logic addr_err(
    input logic [31:0] addr,
    input int unsigned depth
  );
    logic [33:0] lim;
    lim = 34'(depth) << 2;
    return (addr[1:0] != 2'b00) ||
           ({2'b00, addr} >= lim);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-wide storage with byte write enables and a registered read port.
// Storage is deliberately left unreset.
module mem_word_array
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic            i_re,
  input  logic [AW-1:0]   i_idx,
  input  logic [BE_W-1:0] i_be,
  input  logic [31:0]     i_wdata,
  output logic [31:0]     o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for the core's data-memory port.
// One request in flight; wait states, then access, then response.
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_error,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e          r_state;
  state_e          w_next;
  logic [3:0]      r_cnt;
  logic            r_write;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [BE_W-1:0] r_be;
  logic            r_rsp_err;
  logic            r_load_ok;

  logic            w_accept;
  logic            w_commit;
  logic            w_from_req;
  logic            w_acc_write;
  logic [31:0]     w_acc_addr;
  logic [31:0]     w_acc_wdata;
  logic [BE_W-1:0] w_acc_be;
  logic            w_err;
  logic            w_we;
  logic            w_re;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_rdata;

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            w_next = S_WAIT;
          end else begin
            w_next   = S_RESP;
            w_commit = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next   = S_RESP;
          w_commit = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With no wait states the commit edge is the accept edge itself,
  // so the access uses the live request that is being latched.
  assign w_from_req  = (r_state == S_IDLE);
  assign w_acc_write = w_from_req ? req_write : r_write;
  assign w_acc_addr  = w_from_req ? req_addr  : r_addr;
  assign w_acc_wdata = w_from_req ? req_wdata : r_wdata;
  assign w_acc_be    = w_from_req ? req_be    : r_be;

  assign w_err = addr_err(w_acc_addr, DEPTH_WORDS);
  assign w_idx = w_acc_addr[AW+1:2];
  assign w_we  = w_commit && w_acc_write && !w_err;
  assign w_re  = w_commit && !w_acc_write && !w_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_be      <= '0;
      r_rsp_err <= 1'b0;
      r_load_ok <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= WS_LOAD;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rsp_err <= w_err;
        r_load_ok <= !w_acc_write && !w_err;
      end else if (r_state == S_RESP && rsp_ready) begin
        r_rsp_err <= 1'b0;
        r_load_ok <= 1'b0;
      end
    end
  end

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (w_idx),
    .i_be    (w_acc_be),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign rsp_error = r_rsp_err;
  assign rsp_rdata = r_load_ok ? w_rdata : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, corner sequences,
// and random traffic against a byte-level memory model.
module tb_data_mem_responder;

  localparam int DW = 256;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [DW];
  logic [3:0]  kn  [DW];

  data_mem_responder #(
    .DEPTH_WORDS(DW),
    .WAIT_STATES(WS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  be,
    output logic [31:0] erd,
    output logic        eer,
    output logic [31:0] mask
  );
    int wi;
    erd  = '0;
    mask = 32'hFFFF_FFFF;
    eer  = (a % 4 != 0) || (a >= 32'(DW * 4));
    if (eer) return;
    wi = int'(a / 4);
    if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mdl[wi][8*b +: 8] = d[8*b +: 8];
          kn[wi][b] = 1'b1;
        end
      end
    end else begin
      erd  = mdl[wi];
      mask = '0;
      for (int b = 0; b < 4; b++)
        if (kn[wi][b]) mask[8*b +: 8] = 8'hFF;
    end
  endfunction

  task automatic do_req(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  be,
    input  int          hold,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output logic        ok
  );
    int   n;
    logic stable;
    ok = 1'b0; rd = '0; er = 1'b0; lat = 0;
    req_valid = 1'b1; req_write = w; req_addr = a;
    req_wdata = d; req_be = be;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got 0 expected 1");
      return;
    end
    rd = rsp_rdata; er = rsp_error;
    stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== rd ||
          rsp_error !== er || req_ready)
        stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ok = 1'b1;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  initial begin
    vec_t        tv [15];
    logic [31:0] rd, erd, mask;
    logic        er, eer, ok, stay0;
    int          lat;

    for (int i = 0; i < DW; i++) begin
      mdl[i] = '0; kn[i] = '0;
    end

    tv[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    tv[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 32'h10,  32'h00001234, 4'h3, 32'h0, 1'b0};
    tv[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEAD1234, 1'b0};
    tv[4]  = '{1'b1, 32'h0,   32'hA5A50000, 4'hF, 32'h0, 1'b0};
    tv[5]  = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h0, 1'b1};
    tv[6]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
    tv[7]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hA5A50000, 1'b0};
    tv[8]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
    tv[9]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEAD1234, 1'b0};
    tv[10] = '{1'b1, 32'h3FC, 32'h13579BDF, 4'hF, 32'h0, 1'b0};
    tv[11] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h13579BDF, 1'b0};
    tv[12] = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0, 1'b1};
    tv[13] = '{1'b1, 32'h2,   32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
    tv[14] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hA5A50000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rdata",     rsp_rdata,      32'd0);
    chk("rst_error",     32'(rsp_error), 32'd0);
    reset = 1'b1;
    stay0 = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid || busy || !req_ready) stay0 = 1'b0;
    end
    chk("idle_quiet", 32'(stay0), 32'd1);

    for (int i = 0; i < 15; i++) begin
      do_req(tv[i].w, tv[i].a, tv[i].d, tv[i].be, 0,
             rd, er, lat, ok);
      model(tv[i].w, tv[i].a, tv[i].d, tv[i].be, erd, eer, mask);
      if (ok) begin
        chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
        chk($sformatf("vec%0d_error", i), 32'(er),
            32'(tv[i].exp_er));
        chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(WS + 1));
      end
    end

    do_req(1'b0, 32'h10, 32'h0, 4'h0, 10, rd, er, lat, ok);
    if (ok) begin
      chk("bp_rdata",     rd,              32'hDEAD1234);
      chk("bp_req_ready", 32'(req_ready),  32'd1);
      chk("bp_rsp_valid", 32'(rsp_valid),  32'd0);
      chk("bp_busy",      32'(busy),       32'd0);
    end

    do_req(1'b1, 32'h20, 32'h11112222, 4'hF, 0, rd, er, lat, ok);
    model(1'b1, 32'h20, 32'h11112222, 4'hF, erd, eer, mask);
    chk("pre_rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    stay0 = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) stay0 = 1'b0;
    end
    chk("midrst_no_rsp", 32'(stay0), 32'd1);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, ok);
    if (ok) chk("midrst_mem", rd, 32'h11112222);

    for (int i = 0; i < 150; i++) begin
      logic        w;
      logic [31:0] a, d;
      logic [3:0]  be;
      w  = 1'($urandom);
      d  = $urandom;
      be = 4'($urandom);
      case ($urandom_range(0, 9))
        0: a = 32'($urandom_range(0, 255)) * 4 +
               32'($urandom_range(1, 3));
        1: a = 32'h400 + 32'($urandom_range(0, 4000)) * 4;
        2: a = $urandom & 32'hFFFF_FFFC;
        3, 4, 5: a = 32'($urandom_range(0, 255)) * 4;
        default: a = 32'($urandom_range(0, 7)) * 4;
      endcase
      do_req(w, a, d, be, $urandom_range(0, 3), rd, er, lat, ok);
      model(w, a, d, be, erd, eer, mask);
      if (ok) begin
        chk("rnd_error",   32'(er),  32'(eer));
        chk("rnd_rdata",   rd & mask, erd & mask);
        chk("rnd_latency", 32'(lat), 32'(WS + 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
